// File: rtl/cmp_rr_sched_if.sv
// Handshake and comparator-side bundle for cmp_rr_sched.
// The slave modport is the scheduler; the master modport is the clients plus the comparator.
interface cmp_rr_sched_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int W     = 4
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] a_in;
  logic [N_REQ*W-1:0] b_in;
  logic [N_REQ-1:0]   ack;
  logic [W-1:0]       cmp_a;
  logic [W-1:0]       cmp_b;
  logic               cmp_c;
  logic               done;
  logic [ID_W-1:0]    done_id;
  logic               result;
  logic               busy;

  modport slave (
    input  req, a_in, b_in, cmp_c,
    output ack, cmp_a, cmp_b, done, done_id, result, busy
  );

  modport master (
    output req, a_in, b_in, cmp_c,
    input  ack, cmp_a, cmp_b, done, done_id, result, busy
  );
endinterface

// File: rtl/cmp_rr_sched.sv
// Round-robin scheduler sharing one comparator among N_REQ requesters.
// One operation at a time: grant, drive operands, wait CMP_LAT edges, return the tagged bit.
module cmp_rr_sched #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int W       = 4,
  parameter int CMP_LAT = 2
) (
  input  logic           clk,
  input  logic           reset,
  cmp_rr_sched_if.slave  bus
);

  localparam int CNT_W = $clog2(CMP_LAT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] cnt;

  logic             gnt_found;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  idx;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;

  // Search starts just after the last grant; N_REQ is a power of two so ID_W math wraps.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = rr_ptr + ID_W'(k);
      if (!gnt_found && bus.req[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gnt_id == ID_W'(k)) begin
        sel_a = bus.a_in[k*W +: W];
        sel_b = bus.b_in[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= ID_W'(N_REQ - 1);
      cnt         <= '0;
      bus.ack     <= '0;
      bus.cmp_a   <= '0;
      bus.cmp_b   <= '0;
      bus.done    <= 1'b0;
      bus.done_id <= '0;
      bus.result  <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      bus.ack  <= '0;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            bus.ack   <= N_REQ'(1) << gnt_id;
            bus.cmp_a <= sel_a;
            bus.cmp_b <= sel_b;
            rr_ptr    <= gnt_id;
            cnt       <= CNT_W'(CMP_LAT);
            bus.busy  <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          // rr_ptr still holds the id of the outstanding operation.
          if (cnt == CNT_W'(1)) begin
            bus.result  <= bus.cmp_c;
            bus.done_id <= rr_ptr;
            bus.done    <= 1'b1;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_rr_sched.sv
// Directed bench for cmp_rr_sched with a registered signed less-than comparator (CMP_LAT=2).
// Inputs are driven and outputs sampled on the falling edge.
module tb_cmp_rr_sched;

  logic clk;
  logic reset;
  int   checks;
  int   passed;

  cmp_rr_sched_if #(.N_REQ(4), .ID_W(2), .W(4)) bus ();

  cmp_rr_sched #(.N_REQ(4), .ID_W(2), .W(4), .CMP_LAT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.cmp_c <= ($signed(bus.cmp_a) < $signed(bus.cmp_b));

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ops(input int id, input logic [3:0] a, input logic [3:0] b);
    bus.a_in[id*4 +: 4] = a;
    bus.b_in[id*4 +: 4] = b;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    bus.req  = 4'hF;
    bus.a_in = '0;
    bus.b_in = '0;
    set_ops(0, 4'd6, 4'd2);
    set_ops(1, 4'd1, 4'd7);
    repeat (3) step();
    checks++; if (bus.ack !== 4'b0000) $display("FAIL rst_ack: got %b want 0000", bus.ack); else passed++;
    checks++; if (bus.cmp_a !== 4'd0 || bus.cmp_b !== 4'd0) $display("FAIL rst_cmp_ab: got %h/%h want 0/0", bus.cmp_a, bus.cmp_b); else passed++;
    checks++; if (bus.done !== 1'b0 || bus.done_id !== 2'd0) $display("FAIL rst_done: got %b/%0d want 0/0", bus.done, bus.done_id); else passed++;
    checks++; if (bus.result !== 1'b0 || bus.busy !== 1'b0) $display("FAIL rst_res_busy: got %b/%b want 0/0", bus.result, bus.busy); else passed++;
    reset = 1'b1;
    step();
    checks++; if (bus.ack !== 4'b0001) $display("FAIL rst_first_ack: got %b want 0001", bus.ack); else passed++;
    checks++; if (bus.cmp_a !== 4'd6 || bus.cmp_b !== 4'd2) $display("FAIL rst_first_ops: got %h/%h want 6/2", bus.cmp_a, bus.cmp_b); else passed++;
    bus.req = 4'b0000;
    step();
    step();
    checks++; if (bus.done !== 1'b1 || bus.result !== 1'b0) $display("FAIL rst_first_done: got %b/%b want 1/0", bus.done, bus.result); else passed++;
    step();
  endtask

  task automatic test_single();
    logic [3:0] va [3] = '{4'd3, 4'd3, 4'hF};
    logic [3:0] vb [3] = '{4'd1, 4'hF, 4'd3};
    logic       ve [3] = '{1'b0, 1'b0, 1'b1};
    for (int v = 0; v < 3; v++) begin
      set_ops(0, va[v], vb[v]);
      bus.req = 4'b0001;
      step();
      checks++; if (bus.ack !== 4'b0001 || bus.busy !== 1'b1) $display("FAIL single%0d_ack: got %b busy %b want 0001 busy 1", v, bus.ack, bus.busy); else passed++;
      checks++; if (bus.cmp_a !== va[v] || bus.cmp_b !== vb[v]) $display("FAIL single%0d_ops: got %h/%h want %h/%h", v, bus.cmp_a, bus.cmp_b, va[v], vb[v]); else passed++;
      bus.req = 4'b0000;
      step();
      checks++; if (bus.done !== 1'b0 || bus.ack !== 4'b0000 || bus.busy !== 1'b1) $display("FAIL single%0d_e1: got done %b ack %b busy %b want 0 0000 1", v, bus.done, bus.ack, bus.busy); else passed++;
      step();
      checks++; if (bus.done !== 1'b1 || bus.done_id !== 2'd0 || bus.result !== ve[v]) $display("FAIL single%0d_done: got %b id %0d res %b want 1 id 0 res %b", v, bus.done, bus.done_id, bus.result, ve[v]); else passed++;
      checks++; if (bus.busy !== 1'b0) $display("FAIL single%0d_busy_clear: got %b want 0", v, bus.busy); else passed++;
      step();
      checks++; if (bus.done !== 1'b0) $display("FAIL single%0d_done_pulse: got %b want 0", v, bus.done); else passed++;
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] ra [4] = '{4'd1, 4'd7, 4'hD, 4'd5};
    logic [3:0] rb [4] = '{4'd2, 4'd8, 4'hF, 4'd5};
    logic       re [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int id;
    reset = 1'b0;
    step();
    for (int i = 0; i < 4; i++) set_ops(i, ra[i], rb[i]);
    bus.req = 4'hF;
    reset = 1'b1;
    for (int g = 0; g < 5; g++) begin
      id = g % 4;
      step();
      checks++; if (bus.ack !== (4'b0001 << id)) $display("FAIL rr%0d_ack: got %b want %b", g, bus.ack, 4'b0001 << id); else passed++;
      checks++; if (bus.cmp_a !== ra[id] || bus.cmp_b !== rb[id]) $display("FAIL rr%0d_ops: got %h/%h want %h/%h", g, bus.cmp_a, bus.cmp_b, ra[id], rb[id]); else passed++;
      step();
      checks++; if (bus.ack !== 4'b0000) $display("FAIL rr%0d_no_ack_busy: got %b want 0000", g, bus.ack); else passed++;
      step();
      checks++; if (bus.done !== 1'b1 || bus.done_id !== 2'(id) || bus.result !== re[id]) $display("FAIL rr%0d_done: got %b id %0d res %b want 1 id %0d res %b", g, bus.done, bus.done_id, bus.result, id, re[id]); else passed++;
    end
    bus.req = 4'b0000;
    step();
  endtask

  task automatic test_withdraw();
    logic seen2;
    seen2 = 1'b0;
    bus.req = 4'b1110;
    step();
    seen2 |= bus.ack[2];
    checks++; if (bus.ack !== 4'b0010) $display("FAIL wd_first_ack: got %b want 0010", bus.ack); else passed++;
    bus.req = 4'b1000;
    step();
    seen2 |= bus.ack[2];
    step();
    seen2 |= bus.ack[2];
    checks++; if (bus.done !== 1'b1 || bus.done_id !== 2'd1) $display("FAIL wd_done1: got %b id %0d want 1 id 1", bus.done, bus.done_id); else passed++;
    step();
    seen2 |= bus.ack[2];
    checks++; if (bus.ack !== 4'b1000) $display("FAIL wd_skip_to3: got %b want 1000", bus.ack); else passed++;
    bus.req = 4'b0000;
    step();
    seen2 |= bus.ack[2];
    step();
    seen2 |= bus.ack[2];
    checks++; if (bus.done !== 1'b1 || bus.done_id !== 2'd3) $display("FAIL wd_done3: got %b id %0d want 1 id 3", bus.done, bus.done_id); else passed++;
    step();
    seen2 |= bus.ack[2];
    checks++; if (seen2 !== 1'b0) $display("FAIL wd_ack2_seen: got %b want 0", seen2); else passed++;
  endtask

  task automatic test_reset_abort();
    logic seen_done;
    seen_done = 1'b0;
    set_ops(2, 4'd2, 4'd9);
    bus.req = 4'b0100;
    step();
    checks++; if (bus.ack !== 4'b0100) $display("FAIL ab_grant: got %b want 0100", bus.ack); else passed++;
    bus.req = 4'b0000;
    reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.cmp_a !== 4'd0 || bus.cmp_b !== 4'd0 || bus.ack !== 4'b0000) $display("FAIL ab_clear: got busy %b ops %h/%h ack %b want 0 0/0 0000", bus.busy, bus.cmp_a, bus.cmp_b, bus.ack); else passed++;
    repeat (3) begin step(); seen_done |= bus.done; end
    reset = 1'b1;
    repeat (4) begin step(); seen_done |= bus.done; end
    checks++; if (seen_done !== 1'b0) $display("FAIL ab_no_done: got %b want 0", seen_done); else passed++;
    bus.req = 4'hF;
    step();
    checks++; if (bus.ack !== 4'b0001) $display("FAIL ab_restart_ack: got %b want 0001", bus.ack); else passed++;
    bus.req = 4'b0000;
    repeat (3) step();
  endtask

  initial begin
    checks    = 0;
    passed    = 0;
    bus.cmp_c = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_withdraw();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
